// File: rtl/rr_arbiter_8_if.sv
// Handshake bundle between eight requesters and the round-robin arbiter.
// The owner's release strobe is named release_pulse because "release" is a reserved word.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic       release_pulse;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req,
    output release_pulse,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  release_pulse,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time and a one-cycle turnaround
// between grants; drives the select index and one-hot grant for a 3-to-8 decoder.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_8_if.slave  arb
);

  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_r, state_s;
  logic [2:0]       ptr_r, ptr_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [2:0]       grant_idx_r, grant_idx_s;
  logic             grant_valid_r, grant_valid_s;
  logic [7:0]       grant_r, grant_s;
  logic             timeout_r, timeout_s;
  logic [2:0]       pick_s;
  logic             drop_s;
  logic             to_s;

  // First set request bit at or after the priority pointer, wrapping modulo 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] sel;
    sel = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) begin
        sel = idx;
      end
    end
    return sel;
  endfunction

  assign pick_s = rr_pick(arb.req, ptr_r);
  assign drop_s = ~arb.req[grant_idx_r];
  assign to_s   = (hold_cnt_r == CNT_W'(MAX_HOLD - 1));

  // Next-state logic for the IDLE/GRANT controller and its registered outputs.
  always_comb begin
    state_s       = state_r;
    ptr_s         = ptr_r;
    hold_cnt_s    = hold_cnt_r;
    grant_idx_s   = grant_idx_r;
    grant_valid_s = grant_valid_r;
    grant_s       = grant_r;
    timeout_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|arb.req) begin
          state_s       = ST_GRANT;
          grant_idx_s   = pick_s;
          grant_valid_s = 1'b1;
          grant_s       = 8'h01 << pick_s;
          hold_cnt_s    = '0;
        end else begin
          grant_valid_s = 1'b0;
          grant_s       = 8'h00;
        end
      end
      ST_GRANT: begin
        if (drop_s | arb.release_pulse | to_s) begin
          // Release and drop win over the hold limit when reporting the cause.
          state_s       = ST_IDLE;
          ptr_s         = grant_idx_r + 3'd1;
          grant_valid_s = 1'b0;
          grant_s       = 8'h00;
          timeout_s     = to_s & ~drop_s & ~arb.release_pulse;
        end else begin
          hold_cnt_s    = hold_cnt_r + CNT_W'(1'b1);
        end
      end
      default: begin
        state_s       = ST_IDLE;
        grant_valid_s = 1'b0;
        grant_s       = 8'h00;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      ptr_r         <= 3'd0;
      hold_cnt_r    <= '0;
      grant_idx_r   <= 3'd0;
      grant_valid_r <= 1'b0;
      grant_r       <= 8'h00;
      timeout_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      ptr_r         <= ptr_s;
      hold_cnt_r    <= hold_cnt_s;
      grant_idx_r   <= grant_idx_s;
      grant_valid_r <= grant_valid_s;
      grant_r       <= grant_s;
      timeout_r     <= timeout_s;
    end
  end

  assign arb.grant       = grant_r;
  assign arb.grant_idx   = grant_idx_r;
  assign arb.grant_valid = grant_valid_r;
  assign arb.timeout     = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: directed stimulus pushes expected grants
// (index, length, timeout flag); a negedge monitor pops and compares them.
module tb_rr_arbiter_8;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] len;   // 0 = length not checked (grant cut by reset)
    logic       to;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  rr_arbiter_8_if bus();

  rr_arbiter_8 #(.MAX_HOLD(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] idx, input logic [7:0] len, input logic to);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.to  = to;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a grant; exp_wait > 0 also checks the number of cycles waited.
  task automatic wait_grant(input int exp_wait);
    int n;
    n = 0;
    while (!bus.grant_valid && n < 40) begin
      tick();
      n++;
    end
    if (!bus.grant_valid) begin
      check("grant_wait_timeout", 32'(n), 32'd0);
    end else if (exp_wait > 0) begin
      check("turnaround_gap", 32'(n), 32'(exp_wait));
    end
  endtask

  // Hold the current grant for len cycles, then release it (optionally dropping req).
  task automatic grant_release(input int len, input bit drop, input int exp_wait);
    wait_grant(exp_wait);
    repeat (len - 1) tick();
    bus.release_pulse = 1'b1;
    if (drop) bus.req = 8'h00;
    tick();
    bus.release_pulse = 1'b0;
  endtask

  // Monitor: invariant every cycle, grant index/length/timeout against the scoreboard.
  initial begin
    bit   in_grant;
    bit   ended;
    int   len_cnt;
    exp_t cur;
    in_grant = 1'b0;
    len_cnt  = 0;
    cur      = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_grant = 1'b0;
      end else begin
        ended = 1'b0;
        check("onehot_invariant", 32'(bus.grant),
              32'(bus.grant_valid ? (8'h01 << bus.grant_idx) : 8'h00));
        if (bus.grant_valid && !in_grant) begin
          if (exp_q.size() == 0) begin
            check("unexpected_grant", 32'(bus.grant_idx), 32'hFFFF_FFFF);
          end else begin
            cur = exp_q.pop_front();
            check("grant_idx", 32'(bus.grant_idx), 32'(cur.idx));
          end
          in_grant = 1'b1;
          len_cnt  = 1;
        end else if (bus.grant_valid && in_grant) begin
          check("grant_stable", 32'(bus.grant_idx), 32'(cur.idx));
          len_cnt++;
        end else if (!bus.grant_valid && in_grant) begin
          if (cur.len != 8'd0) check("grant_len", 32'(len_cnt), 32'(cur.len));
          in_grant = 1'b0;
          ended    = 1'b1;
        end
        check("timeout_pulse", 32'(bus.timeout), 32'(ended ? cur.to : 1'b0));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.release_pulse = 1'b0;
    #12;
    check("reset_grant", 32'(bus.grant), 32'h00);
    check("reset_valid", 32'(bus.grant_valid), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Fairness: all request, each grant released on its first cycle.
    for (int i = 0; i < 8; i++) push(3'(i), 8'd1, 1'b0);
    push(3'd0, 8'd1, 1'b0);
    bus.req = 8'hFF;
    for (int i = 0; i < 9; i++) grant_release(1, (i == 8), (i == 0) ? 1 : 1);

    // Single requester 5: held 3 cycles, regranted after one idle cycle.
    push(3'd5, 8'd3, 1'b0);
    push(3'd5, 8'd1, 1'b0);
    bus.req = 8'h20;
    grant_release(3, 1'b0, 1);
    grant_release(1, 1'b1, 1);

    // Timeout on requester 3, then wrap-around regrant from ptr=4.
    push(3'd3, 8'd16, 1'b1);
    push(3'd3, 8'd1, 1'b0);
    bus.req = 8'h08;
    wait_grant(1);
    for (int n = 0; n < 40 && bus.grant_valid; n++) tick();
    grant_release(1, 1'b1, 1);

    // Release + drop on the limit cycle: no timeout, ptr moves 4 -> 5.
    push(3'd4, 8'd16, 1'b0);
    push(3'd5, 8'd1, 1'b0);
    bus.req = 8'h10;
    grant_release(16, 1'b1, 1);
    bus.req = 8'h30;
    grant_release(1, 1'b1, 1);

    // Wrap-around between requesters 7 and 0.
    push(3'd7, 8'd1, 1'b0);
    push(3'd0, 8'd1, 1'b0);
    push(3'd7, 8'd1, 1'b0);
    bus.req = 8'h81;
    grant_release(1, 1'b0, 1);
    grant_release(1, 1'b0, 1);
    grant_release(1, 1'b1, 1);

    // Mid-grant asynchronous reset while requester 1 owns the resource.
    push(3'd0, 8'd1, 1'b0);
    push(3'd1, 8'd0, 1'b0);
    bus.req = 8'hFF;
    grant_release(1, 1'b0, 1);
    wait_grant(1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_grant", 32'(bus.grant), 32'h00);
    check("midreset_valid", 32'(bus.grant_valid), 32'd0);
    check("midreset_idx", 32'(bus.grant_idx), 32'd0);
    check("midreset_timeout", 32'(bus.timeout), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    push(3'd0, 8'd1, 1'b0);
    grant_release(1, 1'b1, 0);
    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one 8-way one-hot select resource among eight requesters. It picks one requester by rotating priority and drives that requester's 3-bit index plus the matching one-hot grant (grant = 1 << grant_idx). It holds the grant until the owner releases it, drops its request, or exceeds a hold limit. It sits in front of the 3-to-8 select decoder and sequences which select line is active.

## Interface
- MAX_HOLD, 16: maximum number of consecutive cycles one grant may be held. Legal range is 1..65535; 0 is illegal.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request vector; bit i = requester i wants the resource
- release  input  1  single-cycle pulse from the current owner ending its grant
- grant  output  8  one-hot grant; 8'h00 when no grant is active
- grant_idx  output  3  binary index of the current owner; holds its last value while idle
- grant_valid  output  1  high while a grant is active
- timeout  output  1  single-cycle pulse when a grant is forcibly ended by the hold limit

## Operation
- Internal state:
  - FSM with two states, IDLE and GRANT.
  - 3-bit rotating pointer `ptr` (highest-priority index).
  - hold counter of width clog2(MAX_HOLD), minimum 1 bit.
- All outputs are registered. grant is derived from the registered grant_idx and grant_valid: grant = grant_valid ? (8'h01 << grant_idx) : 8'h00.
- Invariant: grant is always either zero or exactly one-hot and equal to 1 << grant_idx.
- IDLE:
  - grant_valid = 0.
  - If req != 0, select the first set bit searching ptr, ptr+1, … ptr+7 (mod 8).
  - Next state GRANT; grant_idx <= selected index; hold_cnt <= 0.
  - If req == 0, stay in IDLE.
- GRANT: evaluated each cycle on current inputs.
  - drop = !req[grant_idx]
  - rel = release
  - to = (hold_cnt == MAX_HOLD-1)
  - If drop | rel | to: next state IDLE; ptr <= grant_idx + 1 (mod 8, 3-bit wrap 7→0); timeout <= to & !drop & !rel.
  - Otherwise hold_cnt <= hold_cnt + 1; stay in GRANT.
- release while in IDLE is ignored.
- release, drop and to in the same cycle produce one release and timeout stays 0. Release and drop take precedence in reporting.
- The owner may re-request. After release it has the lowest priority, since ptr has moved past it. If it is the only requester, it is granted again after the idle cycle.
- Reset (async, rst_n low):
  - FSM = IDLE, ptr = 0, hold_cnt = 0.
  - grant_idx = 3'd0, grant_valid = 0, grant = 8'h00, timeout = 0.
  - Outputs go to these values immediately, without a clock edge, including when reset arrives mid-grant.

## Timing
- Request to grant: 1 cycle. req is sampled at edge k while IDLE; grant is visible after edge k.
- Grant length: minimum 1 cycle, maximum MAX_HOLD cycles.
- On release (any cause) at edge k, grant_valid = 0 for exactly one cycle after edge k. This is the mandatory turnaround gap. The next grant appears no earlier than after edge k+1.
- timeout is high for exactly the one idle cycle that follows a forced release.
- Back-to-back grants to distinct requesters are therefore spaced by one dead cycle. Peak utilisation is MAX_HOLD/(MAX_HOLD+1).
- MAX_HOLD = 1: every grant lasts one cycle, and timeout pulses after every grant that is not released or dropped.

## Test plan
- **Reset:** assert rst_n=0 mid-sim with req=8'hFF → grant=8'h00, grant_valid=0, grant_idx=0, timeout=0 with no clock edge. After deassert, the first grant is index 0.
- **Single requester:** req=8'h20 held, release pulsed 3 cycles after grant → grant=8'h20 and grant_idx=5 one cycle after req, held 3 cycles, then one idle cycle, then regranted 8'h20.
- **Fairness:** req=8'hFF held, release pulsed on each grant's first cycle → grant sequence 01,02,04,…,80,01 with exactly one idle cycle between grants. Check grant == 1<<grant_idx every cycle.
- **Timeout (MAX_HOLD=16):** req=8'h08 held, release=0 → grant 8'h08 for 16 cycles, timeout=1 on the following idle cycle only, then regrant to 3 via wrap-around search from ptr=4.
- **Simultaneous release:** owner drops req and pulses release on the same cycle that hold_cnt hits MAX_HOLD-1 → single return to IDLE, timeout stays 0, ptr advances by one.
- **Wrap-around:** req=8'h81, grant to 7 released → next grant 0 (ptr wraps 7→0). Then release 0 → next grant 7.
